// File: rtl/serial_word_assembler.sv
// serial_word_assembler
// Frames a single-bit serial stream into WIDTH-bit words. The line idles at 0.
// A frame is one start bit (1), WIDTH data bits LSB first, and one stop bit (0).
// Each completed word goes into a valid/ready output register. frame_err and
// overrun are one-cycle pulses. All outputs are registered.
module serial_word_assembler #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             r,
   input  logic             data,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word,
   output logic             out_valid,
   output logic             frame_err,
   output logic             overrun
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] STOP   = 2'd2;
   localparam logic [1:0] RESYNC = 2'd3;

   logic [1:0]       state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift_reg;

   // Framing FSM, shift register, output register and error pulses
   always_ff @(posedge clock) begin
      if (r) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         out_word  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         // An accepted word empties the register unless a new word lands below
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (data) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
               end
            end

            SHIFT: begin
               shift_reg <= {data, shift_reg[WIDTH-1:1]};
               if (bit_cnt == LAST_BIT) begin
                  state <= STOP;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end

            STOP: begin
               if (!data) begin
                  state <= IDLE;
                  // Load when empty, or when the held word is accepted this same cycle
                  if (!out_valid || out_ready) begin
                     out_word  <= shift_reg;
                     out_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  frame_err <= 1'b1;
                  state     <= RESYNC;
               end
            end

            RESYNC: begin
               // A stuck-high line must drop to 0 before a new start is honoured
               if (!data) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed self-checking bench for serial_word_assembler (WIDTH = 16).
module tb_serial_word_assembler;

   logic        clock;
   logic        r;
   logic        data;
   logic        out_ready;
   logic [15:0] out_word;
   logic        out_valid;
   logic        frame_err;
   logic        overrun;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Observed transfers and pulses, captured on the falling edge
   logic [15:0] acc_q[$];
   int          acc_cyc_q[$];
   int          fe_cnt = 0;
   int          ov_cnt = 0;

   serial_word_assembler #(.WIDTH(16)) dut (
      .clock     (clock),
      .r         (r),
      .data      (data),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_valid (out_valid),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record transfers (valid & ready) and error pulses each cycle
   always @(negedge clock) begin
      if (out_valid && out_ready) begin
         acc_q.push_back(out_word);
         acc_cyc_q.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
   end

   task automatic tick();
      @(posedge clock);
      cyc++;
      #1;
   endtask

   task automatic drive_bit(input logic b);
      data = b;
      tick();
   endtask

   task automatic send_body(input logic [15:0] w);
      drive_bit(1'b1);
      for (int i = 0; i < 16; i++) drive_bit(w[i]);
   endtask

   task automatic clear_log();
      acc_q.delete();
      acc_cyc_q.delete();
      fe_cnt = 0;
      ov_cnt = 0;
   endtask

   task automatic idle(input int n);
      data = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      r = 1'b1; data = 1'b0; out_ready = 1'b0;
      tick(); tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_word !== 16'h0000) begin bad++; $display("FAIL reset_word got=%h exp=0000", out_word); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      r = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         total++;
         if ({out_valid, frame_err, overrun} !== 3'b000) begin
            bad++;
            $display("FAIL idle_outputs cyc=%0d got=%b exp=000", i, {out_valid, frame_err, overrun});
         end
      end
      total++; if (out_word !== 16'h0000) begin bad++; $display("FAIL idle_word got=%h exp=0000", out_word); end
   endtask

   task automatic test_single_frame();
      int start_cyc;
      clear_log();
      out_ready = 1'b1;
      drive_bit(1'b1);
      start_cyc = cyc;
      for (int i = 0; i < 16; i++) drive_bit(w_a5c3(i));
      drive_bit(1'b0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      total++; if (out_word !== 16'hA5C3) begin bad++; $display("FAIL single_word got=%h exp=a5c3", out_word); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b exp=0", out_valid); end
      total++; if (out_word !== 16'hA5C3) begin bad++; $display("FAIL single_word_retained got=%h exp=a5c3", out_word); end
      idle(3);
      total++;
      if (acc_q.size() != 1) begin
         bad++; $display("FAIL single_count got=%0d exp=1", acc_q.size());
      end else if (acc_cyc_q[0] - start_cyc != 17) begin
         bad++; $display("FAIL single_latency got=%0d exp=17", acc_cyc_q[0] - start_cyc);
      end
   endtask

   function automatic logic w_a5c3(input int i);
      logic [15:0] w;
      w = 16'hA5C3;
      return w[i];
   endfunction

   task automatic test_back_to_back();
      clear_log();
      out_ready = 1'b1;
      send_body(16'h1234); drive_bit(1'b0);
      send_body(16'hFFFF); drive_bit(1'b0);
      idle(5);
      total++;
      if (acc_q.size() != 2) begin
         bad++; $display("FAIL b2b_count got=%0d exp=2", acc_q.size());
      end else begin
         total++; if (acc_q[0] !== 16'h1234) begin bad++; $display("FAIL b2b_word0 got=%h exp=1234", acc_q[0]); end
         total++; if (acc_q[1] !== 16'hFFFF) begin bad++; $display("FAIL b2b_word1 got=%h exp=ffff", acc_q[1]); end
         total++; if (acc_cyc_q[1] - acc_cyc_q[0] != 18) begin bad++; $display("FAIL b2b_spacing got=%0d exp=18", acc_cyc_q[1] - acc_cyc_q[0]); end
      end
      total++; if (fe_cnt + ov_cnt != 0) begin bad++; $display("FAIL b2b_errors got=%0d exp=0", fe_cnt + ov_cnt); end
   endtask

   task automatic test_frame_error();
      clear_log();
      out_ready = 1'b1;
      send_body(16'h00FF); drive_bit(1'b1);
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ferr_no_output got=%b exp=0", out_valid); end
      for (int i = 0; i < 5; i++) drive_bit(1'b1);
      drive_bit(1'b0);
      send_body(16'h0001); drive_bit(1'b0);
      idle(4);
      total++; if (fe_cnt != 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt); end
      total++;
      if (acc_q.size() != 1) begin
         bad++; $display("FAIL ferr_delivered_count got=%0d exp=1", acc_q.size());
      end else if (acc_q[0] !== 16'h0001) begin
         bad++; $display("FAIL ferr_good_word got=%h exp=0001", acc_q[0]);
      end
   endtask

   task automatic test_overrun();
      clear_log();
      out_ready = 1'b0;
      send_body(16'hBEEF); drive_bit(1'b0);
      send_body(16'hCAFE); drive_bit(1'b0);
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
      total++; if (out_word !== 16'hBEEF) begin bad++; $display("FAIL ovr_held_word got=%h exp=beef", out_word); end
      idle(1);
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_single got=%b exp=0", overrun); end
      idle(3);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_still_valid got=%b exp=1", out_valid); end
      out_ready = 1'b1;
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_drop got=%b exp=0", out_valid); end
      total++;
      if (acc_q.size() != 1) begin
         bad++; $display("FAIL ovr_accept_count got=%0d exp=1", acc_q.size());
      end else if (acc_q[0] !== 16'hBEEF) begin
         bad++; $display("FAIL ovr_accepted got=%h exp=beef", acc_q[0]);
      end
      total++; if (ov_cnt != 1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", ov_cnt); end

      // Accept and reload in the same completing cycle
      clear_log();
      out_ready = 1'b0;
      send_body(16'h1111); drive_bit(1'b0);
      idle(2);
      send_body(16'h2222);
      out_ready = 1'b1;
      drive_bit(1'b0);
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL simul_overrun got=%b exp=0", overrun); end
      total++; if (out_word !== 16'h2222) begin bad++; $display("FAIL simul_word got=%h exp=2222", out_word); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL simul_valid got=%b exp=1", out_valid); end
      idle(1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL simul_valid_drop got=%b exp=0", out_valid); end
      total++;
      if (acc_q.size() != 2) begin
         bad++; $display("FAIL simul_count got=%0d exp=2", acc_q.size());
      end else if (acc_q[0] !== 16'h1111 || acc_q[1] !== 16'h2222) begin
         bad++; $display("FAIL simul_order got=%h,%h exp=1111,2222", acc_q[0], acc_q[1]);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] w;
      w = 16'h5555;
      // Leave a word held so the reset has something to discard
      out_ready = 1'b0;
      send_body(16'h3C3C); drive_bit(1'b0);
      idle(2);
      drive_bit(1'b1);
      for (int i = 0; i < 8; i++) drive_bit(w[i]);
      r = 1'b1;
      drive_bit(w[8]);
      r = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
      total++; if (out_word !== 16'h0000) begin bad++; $display("FAIL rst_mid_word got=%h exp=0000", out_word); end
      total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL rst_mid_pulses got=%b exp=00", {frame_err, overrun}); end
      clear_log();
      out_ready = 1'b1;
      // Remaining bits: bit10 reads as a start, bits 11..15 then zeros form 0x000A
      for (int i = 9; i < 16; i++) drive_bit(w[i]);
      drive_bit(1'b0);
      idle(25);
      send_body(16'h0F0F); drive_bit(1'b0);
      idle(4);
      total++;
      if (acc_q.size() != 2) begin
         bad++; $display("FAIL rst_mid_count got=%0d exp=2", acc_q.size());
      end else begin
         total++; if (acc_q[0] !== 16'h000A) begin bad++; $display("FAIL rst_mid_spurious got=%h exp=000a", acc_q[0]); end
         total++; if (acc_q[1] !== 16'h0F0F) begin bad++; $display("FAIL rst_mid_clean got=%h exp=0f0f", acc_q[1]); end
      end
      total++; if (fe_cnt + ov_cnt != 0) begin bad++; $display("FAIL rst_mid_errors got=%0d exp=0", fe_cnt + ov_cnt); end
   endtask

   initial begin
      r = 1'b1; data = 1'b0; out_ready = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_frame_error();
      test_overrun();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_word_assembler.md
# serial_word_assembler

Downstream consumer of the single-bit registered stream produced by the reset-capable D flip-flop stage. It frames that stream into WIDTH-bit words using a start bit and a stop bit, and shifts in the data bits LSB first. Each completed word is presented on a valid/ready output register. Framing errors and overruns are flagged with single-cycle pulses.

## Interface
- WIDTH, 16, data bits per frame (≥2).
- clock  input  1  rising-edge clock; single clock domain.
- r  input  1  reset, synchronous, active-high; sampled on rising edge of clock.
- data  input  1  serial line from upstream flip-flop; idles at 0 (upstream reset value).
- out_ready  input  1  downstream accepts out_word when high with out_valid.
- out_word  output  WIDTH  assembled word, bit 0 = first data bit received.
- out_valid  output  1  out_word holds an unaccepted word.
- frame_err  output  1  one-cycle pulse: stop bit was 1.
- overrun  output  1  one-cycle pulse: completed word dropped because output register was full.

## Operation
- All state is sampled on the rising edge of clock. r has priority over everything.
- Reset values: state=IDLE, bit counter=0, shift register=0, out_word=0, out_valid=0, frame_err=0, overrun=0.
- Line protocol: idle 0, start bit 1, WIDTH data bits LSB first, stop bit 0. One bit per clock.
- FSM states:
  - IDLE: data=1 → SHIFT with counter cleared; data=0 → stay.
  - SHIFT: shift register ← {data, shift[WIDTH-1:1]}; counter increments. On the WIDTH-th bit (counter=WIDTH-1) → STOP.
  - STOP, data=0: word complete; go to IDLE. A start bit can therefore be sampled on the very next cycle.
  - STOP, data=1: pulse frame_err; word discarded; go to RESYNC.
  - RESYNC: stay while data=1; data=0 → IDLE. This prevents a stuck-high line from being read as repeated starts.
- Output register (on word complete):
  - out_valid=0: load out_word and set out_valid.
  - out_valid=1 and out_ready=1 in the same cycle: old word is accepted; new word loads; out_valid stays 1.
  - out_valid=1 and out_ready=0: pulse overrun; new word dropped; held out_word and out_valid unchanged.
- Handshake: transfer occurs on a cycle where out_valid & out_ready. With no new word completing that cycle, out_valid → 0 next cycle. out_word retains its last value after acceptance.
- out_word never changes while out_valid=1 and out_ready=0.
- Counter width: clog2(WIDTH); no wrap beyond WIDTH-1.
- Assertion of r mid-frame or mid-hold aborts everything: the partial word and any held word are lost, and all outputs return to reset values on the next edge.

## Timing
- Start bit sampled at edge T. Data bits sampled at T+1 … T+WIDTH; stop bit at T+WIDTH+1.
- out_valid and out_word are visible after edge T+WIDTH+1, i.e. usable in cycle T+WIDTH+2.
- frame_err is high for exactly the cycle after the stop-bit edge.
- overrun is high for exactly the cycle after the completing edge.
- Minimum frame spacing: WIDTH+2 cycles (back-to-back frames with no idle gap are legal).
- Sustained throughput needs no stall when out_ready is asserted at least once per WIDTH+2 cycles.
- All outputs are registered; no combinational path from data or out_ready to any output.

## Test plan
- Reset then idle: r=1 for 2 cycles, then data=0 for 40 cycles → out_valid, frame_err and overrun stay 0; out_word=0.
- Single frame: WIDTH=16, send start, 0xA5C3 LSB first, stop=0, out_ready=1 → out_valid=1 for one cycle with out_word=0xA5C3, starting WIDTH+2 cycles after the start edge.
- Back-to-back: frames 0x1234 then 0xFFFF with no gap, out_ready=1 → two valid cycles 18 cycles apart carrying 0x1234 then 0xFFFF; no error pulses.
- Framing error: frame 0x00FF with stop=1, then data held 1 for 5 cycles, then 0, then a good frame 0x0001 → frame_err pulses once; no output for the bad frame; 0x0001 delivered.
- Backpressure/overrun: out_ready=0, send 0xBEEF then 0xCAFE → out_word=0xBEEF held; overrun pulses once when 0xCAFE completes. Then raise out_ready → 0xBEEF accepted and out_valid drops. Simultaneous case: the completion cycle has out_ready=1 → no overrun; out_word updates to the new word.
- Reset mid-frame: r=1 for one cycle after 8 data bits of 0x5555 → all outputs 0. Remaining line bits are treated as idle or start per the FSM; a following clean frame 0x0F0F is delivered correctly.
